// File: rtl/urv_mem_pkg.sv
// Shared types and constants for the urv_cpu single-port memory arbiter.
package urv_mem_pkg;

  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_IFETCH = 2'd1,
    TAG_DLOAD  = 2'd2,
    TAG_DIO    = 2'd3
  } tag_e;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_FETCH = 2'd1,
    REQ_LOAD  = 2'd2,
    REQ_STORE = 2'd3
  } req_kind_e;

  localparam logic [31:0] IO_ADDR_DEFAULT = 32'h1000_0000;

endpackage

// File: rtl/urv_arb_prio.sv
// Eligibility masking and data-over-fetch grant selection.
// With URV_ARB_FAIR_EN defined, a starvation counter forces a fetch grant.
module urv_arb_prio
  import urv_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic im_req_i,
  input  logic dm_req_i,
  input  logic fetch_busy_i,
  input  logic data_busy_i,
  output logic gnt_fetch_o,
  output logic gnt_data_o
);

  logic fetch_elig;
  logic data_elig;
  logic fetch_first;

  // A requester with a response in flight sits out this cycle.
  assign fetch_elig = im_req_i && !fetch_busy_i && !rst_i;
  assign data_elig  = dm_req_i && !data_busy_i && !rst_i;

`ifdef URV_ARB_FAIR_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_q;

  assign fetch_first = (starve_q >= CW'(STARVE_MAX));

  // Counts data grants that overtook an eligible fetch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else if (gnt_fetch_o) begin
      starve_q <= '0;
    end else if (gnt_data_o && fetch_elig && !fetch_first) begin
      starve_q <= starve_q + CW'(1);
    end
  end
`else
  logic unused_fair;

  assign fetch_first = 1'b0;
  assign unused_fair = clk_i ^ (STARVE_MAX == 0);
`endif

  assign gnt_fetch_o = fetch_elig && (!data_elig || fetch_first);
  assign gnt_data_o  = data_elig && !gnt_fetch_o;

endmodule

// File: rtl/urv_mem_arbiter.sv
// Shares one single-port RAM between urv_cpu fetch and data ports, with one I/O word.
// Optional fetch starvation guard: define URV_ARB_FAIR_EN.
module urv_mem_arbiter
  import urv_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 16,
  parameter logic [31:0] IO_ADDR    = IO_ADDR_DEFAULT,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 im_req_i,
  input  logic [31:0]          im_addr_i,
  output logic [31:0]          im_data_o,
  output logic                 im_valid_o,
  input  logic [31:0]          dm_addr_i,
  input  logic [31:0]          dm_data_s_i,
  input  logic [3:0]           dm_data_select_i,
  input  logic                 dm_load_i,
  input  logic                 dm_store_i,
  output logic [31:0]          dm_data_l_o,
  output logic                 dm_load_done_o,
  output logic                 dm_store_done_o,
  output logic                 dm_ready_o,
  output logic                 ram_en_o,
  output logic [ADDR_BITS-3:0] ram_addr_o,
  output logic [3:0]           ram_we_o,
  output logic [31:0]          ram_wdata_o,
  input  logic [31:0]          ram_rdata_i,
  output logic                 io_we_o,
  output logic [31:0]          io_wdata_o,
  input  logic [31:0]          io_rdata_i
);

  tag_e        tag_q;
  logic        store_done_q;
  logic [31:0] io_hold_q;

  req_kind_e   dm_kind;
  logic        dm_is_io;
  logic        fetch_busy;
  logic        data_busy;
  logic        gnt_fetch;
  logic        gnt_data;
  logic        unused_im_addr;

  // Store wins if the CPU ever raises load and store together.
  assign dm_kind    = dm_store_i ? REQ_STORE : (dm_load_i ? REQ_LOAD : REQ_NONE);
  assign dm_is_io   = (dm_addr_i == IO_ADDR);
  assign fetch_busy = (tag_q == TAG_IFETCH);
  assign data_busy  = (tag_q == TAG_DLOAD) || (tag_q == TAG_DIO) || store_done_q;

  assign unused_im_addr = ^{im_addr_i[31:ADDR_BITS], im_addr_i[1:0]};

  urv_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .im_req_i     (im_req_i),
    .dm_req_i     (dm_kind != REQ_NONE),
    .fetch_busy_i (fetch_busy),
    .data_busy_i  (data_busy),
    .gnt_fetch_o  (gnt_fetch),
    .gnt_data_o   (gnt_data)
  );

  // RAM and I/O strobes are driven in the grant cycle.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = '0;
    ram_wdata_o = '0;
    io_we_o     = 1'b0;
    io_wdata_o  = '0;
    if (gnt_data) begin
      if (dm_is_io) begin
        if (dm_kind == REQ_STORE) begin
          io_we_o    = 1'b1;
          io_wdata_o = dm_data_s_i;
        end
      end else begin
        ram_en_o   = 1'b1;
        ram_addr_o = dm_addr_i[ADDR_BITS-1:2];
        if (dm_kind == REQ_STORE) begin
          ram_we_o    = dm_data_select_i;
          ram_wdata_o = dm_data_s_i;
        end
      end
    end else if (gnt_fetch) begin
      ram_en_o   = 1'b1;
      ram_addr_o = im_addr_i[ADDR_BITS-1:2];
    end
  end

  // Owner of the response arriving next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q        <= TAG_NONE;
      store_done_q <= 1'b0;
      io_hold_q    <= '0;
    end else begin
      tag_q        <= TAG_NONE;
      store_done_q <= 1'b0;
      if (gnt_data) begin
        if (dm_kind == REQ_STORE) begin
          store_done_q <= 1'b1;
        end else if (dm_is_io) begin
          tag_q     <= TAG_DIO;
          io_hold_q <= io_rdata_i;
        end else begin
          tag_q <= TAG_DLOAD;
        end
      end else if (gnt_fetch) begin
        tag_q <= TAG_IFETCH;
      end
    end
  end

  // Response steering; reset suppresses any pulse from a discarded access.
  always_comb begin
    im_valid_o      = 1'b0;
    im_data_o       = '0;
    dm_load_done_o  = 1'b0;
    dm_data_l_o     = '0;
    dm_store_done_o = store_done_q && !rst_i;
    dm_ready_o      = rst_i || !data_busy;
    if (!rst_i) begin
      case (tag_q)
        TAG_IFETCH: begin
          im_valid_o = 1'b1;
          im_data_o  = ram_rdata_i;
        end
        TAG_DLOAD: begin
          dm_load_done_o = 1'b1;
          dm_data_l_o    = ram_rdata_i;
        end
        TAG_DIO: begin
          dm_load_done_o = 1'b1;
          dm_data_l_o    = io_hold_q;
        end
        default: ;
      endcase
    end
  end

endmodule
